// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory target for the load/store port of the core. Accepts one
// request at a time, validates alignment, size code and address range,
// waits WAIT_STATES cycles, then performs a byte-lane-correct store or a
// sign/zero-extended load on an internal word array. The response is held
// until the consumer takes it.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   WAIT_STATES  extra cycles between acceptance and response (0..15)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  block can accept a request (high only in IDLE)
//   req_addr   byte address
//   req_wdata  store data, right-aligned (SB uses [7:0], SH uses [15:0])
//   req_write  1 = store, 0 = load
//   req_size   funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   rsp_valid  response present (high only in RESP)
//   rsp_rdata  extended load result; 0 for stores and errors
//   rsp_err    request rejected, memory left unchanged
//   rsp_ready  response consumer ready
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        rsp_ready
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    // One past the last valid byte address; 33 bits so the compare is safe
    // even when the array covers the whole 32-bit space.
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0
                                                          : 4'(WAIT_STATES - 1);

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [2:0]  size_q, size_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        req_err;
    logic        do_access;
    logic        acc_from_inputs;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_write;
    logic [2:0]  acc_size;
    logic        acc_err;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0] rd_word;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;
    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;
    logic        mem_we;

    // Classifies an incoming request; any hit means the request is answered
    // with an error and never touches the array.
    function automatic logic reqError(input logic [31:0] addr,
                                      input logic        write,
                                      input logic [2:0]  size);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_BU:   bad = write;
            SZ_H:    bad = addr[0];
            SZ_HU:   bad = addr[0] | write;
            SZ_W:    bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        if ({1'b0, addr} >= ADDR_LIMIT) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    assign req_err = reqError(req_addr, req_write, req_size);

    // With zero wait states the access happens on the acceptance edge, so the
    // datapath must look at the live request rather than the latched copy.
    always_comb begin
        acc_from_inputs = (state_q == IDLE);
        acc_addr  = acc_from_inputs ? req_addr  : addr_q;
        acc_wdata = acc_from_inputs ? req_wdata : wdata_q;
        acc_write = acc_from_inputs ? req_write : write_q;
        acc_size  = acc_from_inputs ? req_size  : size_q;
        acc_err   = acc_from_inputs ? req_err   : err_q;
    end

    assign acc_idx = acc_addr[IDX_W+1:2];
    assign rd_word = mem[acc_idx];

    // Lane selection and extension for loads.
    always_comb begin
        lane_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];
        lane_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = 32'd0;
        case (acc_size)
            SZ_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
            SZ_BU:   load_data = {24'd0, lane_byte};
            SZ_H:    load_data = {{16{lane_half[15]}}, lane_half};
            SZ_HU:   load_data = {16'd0, lane_half};
            SZ_W:    load_data = rd_word;
            default: load_data = 32'd0;
        endcase
    end

    // Byte enables and replicated store data so each lane sees its byte.
    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = acc_wdata;
        case (acc_size)
            SZ_B: begin
                byte_en   = 4'b0001 << acc_addr[1:0];
                wdata_rep = {4{acc_wdata[7:0]}};
            end
            SZ_H: begin
                byte_en   = acc_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{acc_wdata[15:0]}};
            end
            SZ_W: begin
                byte_en   = 4'b1111;
                wdata_rep = acc_wdata;
            end
            default: begin
                byte_en   = 4'b0000;
                wdata_rep = acc_wdata;
            end
        endcase
    end

    // Gated with rst_n so a request presented while reset is held can never
    // reach the array.
    assign mem_we = do_access & acc_write & ~acc_err & rst_n;

    // Array is deliberately not reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[acc_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // Next-state logic: latch the request in IDLE, count down in WAIT,
    // perform the access on the last waiting edge, hold the response in RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        size_d    = size_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        rsp_err_d = rsp_err_q;
        do_access = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    size_d  = req_size;
                    err_d   = req_err;
                    if (WAIT_STATES == 0) begin
                        do_access = 1'b1;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_access) begin
            rsp_err_d = acc_err;
            rdata_d   = (acc_err || acc_write) ? 32'd0 : load_data;
        end
    end

    // State and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            write_q   <= 1'b0;
            size_q    <= 3'b000;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            size_q    <= size_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed, self-checking bench for dmem_responder with WAIT_STATES=2 and
// DEPTH_WORDS=1024. Each request pushes its expected response onto a
// scoreboard queue; the response side pops and compares it.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WS    = 2;
    localparam int          TIMEOUT = 20;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic [2:0]  req_size;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_ready;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t expQ[$];
    int   assertCount;
    int   failCount;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_write (req_write),
        .req_size  (req_size),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkEq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Waits for req_ready, presents one request for exactly one edge and
    // records the response it should produce.
    task automatic applyStimulus(input logic wr, input logic [2:0] sz,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic expErr, input logic [31:0] expData);
        exp_t e;
        int   waited;
        waited = 0;
        while (!req_ready && waited < TIMEOUT) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkEq("reqReadyBeforeReq", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.err  = expErr;
        e.data = expData;
        expQ.push_back(e);
        checkEq("reqReadyInWait", {31'd0, req_ready}, 32'd0);
    endtask

    // Waits (bounded) for the response, checks latency and contents against
    // the scoreboard, optionally applies backpressure with a stray request,
    // then completes the handshake.
    task automatic checkOutput(input int holdCycles);
        exp_t e;
        int   edges;
        edges = 0;
        while (!rsp_valid && edges < TIMEOUT) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkEq("latency", 32'(edges), 32'(WS));
        checkEq("scoreboardDepth", 32'(expQ.size()), 32'd1);
        e = '0;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
        end
        checkEq("rspErr", {31'd0, rsp_err}, {31'd0, e.err});
        checkEq("rspRdata", rsp_rdata, e.data);
        for (int i = 0; i < holdCycles; i++) begin
            if (i == 1) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_size  = SZ_W;
                req_addr  = 32'h10;
                req_wdata = 32'h0;
            end
            if (i == 3) begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            checkEq("holdRspValid", {31'd0, rsp_valid}, 32'd1);
            checkEq("holdRspRdata", rsp_rdata, e.data);
            checkEq("holdReqReady", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkEq("rspValidAfterHs", {31'd0, rsp_valid}, 32'd0);
        checkEq("reqReadyAfterHs", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic doTxn(input logic wr, input logic [2:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic expErr, input logic [31:0] expData);
        applyStimulus(wr, sz, addr, wd, expErr, expData);
        checkOutput(0);
    endtask

    // Directed sequence: reset, word/byte/halfword traffic, errors,
    // backpressure and reset during the wait phase.
    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = SZ_W;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;

        #12;
        checkEq("resetReqReady", {31'd0, req_ready}, 32'd1);
        checkEq("resetRspValid", {31'd0, rsp_valid}, 32'd0);
        checkEq("resetRspRdata", rsp_rdata, 32'd0);
        checkEq("resetRspErr", {31'd0, rsp_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] word store/load");
        doTxn(1'b1, SZ_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        doTxn(1'b0, SZ_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        $display("[TB] byte lanes");
        doTxn(1'b1, SZ_B,  32'h13, 32'h00000080, 1'b0, 32'h0);
        doTxn(1'b0, SZ_B,  32'h13, 32'h0, 1'b0, 32'hFFFFFF80);
        doTxn(1'b0, SZ_BU, 32'h13, 32'h0, 1'b0, 32'h00000080);
        doTxn(1'b0, SZ_W,  32'h10, 32'h0, 1'b0, 32'h80ADBEEF);

        $display("[TB] halfword lanes");
        doTxn(1'b1, SZ_H,  32'h10, 32'h0000F234, 1'b0, 32'h0);
        doTxn(1'b0, SZ_H,  32'h10, 32'h0, 1'b0, 32'hFFFFF234);
        doTxn(1'b0, SZ_HU, 32'h10, 32'h0, 1'b0, 32'h0000F234);
        doTxn(1'b0, SZ_W,  32'h10, 32'h0, 1'b0, 32'h80ADF234);
        doTxn(1'b0, SZ_H,  32'h12, 32'h0, 1'b0, 32'hFFFF80AD);
        doTxn(1'b0, SZ_B,  32'h11, 32'h0, 1'b0, 32'hFFFFFFF2);
        doTxn(1'b0, SZ_BU, 32'h12, 32'h0, 1'b0, 32'h000000AD);

        $display("[TB] last word and error responses");
        doTxn(1'b1, SZ_W, 32'hFFC, 32'hCAFEF00D, 1'b0, 32'h0);
        doTxn(1'b0, SZ_W, 32'hFFC, 32'h0, 1'b0, 32'hCAFEF00D);
        doTxn(1'b1, SZ_W, 32'h0, 32'h11223344, 1'b0, 32'h0);
        doTxn(1'b0, SZ_W, 32'h11, 32'h0, 1'b1, 32'h0);
        doTxn(1'b1, SZ_H, 32'h15, 32'h0000BEEF, 1'b1, 32'h0);
        doTxn(1'b1, SZ_W, 32'h1000, 32'h55555555, 1'b1, 32'h0);
        doTxn(1'b0, SZ_W, 32'h0, 32'h0, 1'b0, 32'h11223344);
        doTxn(1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 32'h0);
        doTxn(1'b1, SZ_BU, 32'h0, 32'h000000FF, 1'b1, 32'h0);
        doTxn(1'b0, SZ_W, 32'h0, 32'h0, 1'b0, 32'h11223344);

        $display("[TB] response backpressure");
        applyStimulus(1'b0, SZ_W, 32'h10, 32'h0, 1'b0, 32'h80ADF234);
        checkOutput(5);
        doTxn(1'b0, SZ_W, 32'h10, 32'h0, 1'b0, 32'h80ADF234);

        $display("[TB] reset during wait");
        doTxn(1'b1, SZ_W, 32'h20, 32'hA5A5A5A5, 1'b0, 32'h0);
        doTxn(1'b0, SZ_W, 32'h20, 32'h0, 1'b0, 32'hA5A5A5A5);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = SZ_W;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkEq("midWaitReqReady", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #2;
        checkEq("midResetReqReady", {31'd0, req_ready}, 32'd1);
        checkEq("midResetRspValid", {31'd0, rsp_valid}, 32'd0);
        checkEq("midResetRspRdata", rsp_rdata, 32'd0);
        checkEq("midResetRspErr", {31'd0, rsp_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        doTxn(1'b0, SZ_W, 32'h20, 32'h0, 1'b0, 32'hA5A5A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Handshaked data-memory target that services the load/store side of the core. It accepts one request at a time, checks its alignment, size code and address range, then waits a fixed number of wait states. It then performs a byte-lane-correct store or a sign/zero-extended load on an internal word array and returns a held response. It is the memory end of the core's load/store port, used when memory latency is not zero.

## Interface
- DEPTH_WORDS, 1024 — number of 32-bit words; power of two, ≥ 4.
- WAIT_STATES, 1 — extra cycles between request acceptance and the response; range 0..15.
- clk  input  1  — clock; all state updates on the rising edge.
- rst_n  input  1  — reset; one clock; reset is asynchronous and active-low.
- req_valid  input  1  — request present.
- req_ready  output  1  — block can accept a request.
- req_addr  input  32  — byte address.
- req_wdata  input  32  — store data, right-aligned: SB uses [7:0], SH uses [15:0].
- req_write  input  1  — 1 = store, 0 = load.
- req_size  input  3  — funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rsp_valid  output  1  — response present.
- rsp_rdata  output  32  — load result, already extended; 0 for stores and errors.
- rsp_err  output  1  — request rejected; memory is unchanged.
- rsp_ready  input  1  — response consumer ready.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- **IDLE:** req_ready=1. A request is accepted when req_valid && req_ready. On acceptance, latch addr, wdata, write, size and evaluate the error conditions.
  - If WAIT_STATES==0: go to RESP, performing the access on the same edge.
  - Otherwise: go to WAIT with the counter loaded to WAIT_STATES−1.
- **WAIT:** req_ready=0. Decrement the counter each cycle. When it reaches 0, perform the access and go to RESP.
- **RESP:** rsp_valid=1. rsp_rdata and rsp_err are held stable. On rsp_ready, go to IDLE.
- Only one request is outstanding at a time. req_valid outside IDLE is ignored and not queued.
- **Error conditions** (any one sets rsp_err=1 and rsp_rdata=0; no write occurs):
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠00.
  - req_size of 011, 110 or 111.
  - Store with size 100 or 101.
  - addr ≥ DEPTH_WORDS×4.
- An erroring request still observes the full WAIT_STATES latency.
- **Word index:** addr[log2(DEPTH_WORDS)+1:2].
- **Stores:**
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lane pair addr[1] with wdata[15:0].
  - SW writes all four bytes.
  - Unselected bytes are preserved.
- **Loads:** select the lane(s) by addr[1:0].
  - B and H sign-extend from bit 7 or bit 15.
  - BU and HU zero-extend.
  - W returns the word unchanged.
- Load data is captured into the rsp_rdata register on the access edge. A later request observes all earlier stores.
- Array contents are not reset; they are undefined until written.

## Timing
- **Reset values:** state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- **Latency:** with the request accepted on edge N, rsp_valid rises after edge N+1+WAIT_STATES−1. It is first visible in the cycle following edge N+WAIT_STATES (WAIT_STATES=0 gives visible right after edge N).
- Response-to-next-acceptance: at least one cycle. req_ready returns high in the cycle after the rsp_valid && rsp_ready edge.
- Back-to-back throughput: one transaction per WAIT_STATES+2 cycles when rsp_ready is held high.
- rsp_valid stays high, with data stable, for as long as rsp_ready is low.
- **Reset mid-operation:**
  - Reset in WAIT aborts the request; a pending store is not written.
  - Reset in RESP drops the response; a store already performed remains.
- Reset deassertion is seen at the next rising edge. A request can be accepted on the first edge after deassertion.

## Test plan
- **Word store and load latency.** WAIT_STATES=2: SW 0xDEADBEEF at 0x10 accepted at edge N, then LW 0x10.
  - rsp_valid is visible after edge N+2 with rsp_err=0.
  - The load returns 0xDEADBEEF.
- **Byte lanes.** SB 0x80 at 0x13, then:
  - LB 0x13 → 0xFFFFFF80.
  - LBU 0x13 → 0x00000080.
  - LW 0x10 → 0x80ADBEEF.
- **Halfword lanes.** SH 0xF234 at 0x10, then:
  - LH 0x10 → 0xFFFFF234.
  - LHU 0x10 → 0x0000F234.
  - LW 0x10 → 0x80ADF234.
- **Error responses.**
  - LW 0x11 → rsp_err=1, rdata 0.
  - SH 0x15 → rsp_err=1.
  - SW 0x1000 with DEPTH_WORDS=1024 → rsp_err=1; a subsequent LW 0x0 is unchanged.
  - Size 011 → rsp_err=1.
- **Response backpressure.** rsp_ready held low 5 cycles with req_valid pulsed during that window.
  - rsp_valid and rsp_rdata stay stable.
  - req_ready stays 0 and no second request is accepted.
  - After rsp_ready rises, the next request completes normally.
- **Reset mid-operation.** rst_n pulsed low during WAIT of SW 0x12345678 at 0x20 (0x20 previously holds 0xA5A5A5A5).
  - Outputs return to reset values.
  - LW 0x20 returns 0xA5A5A5A5.
